// File: rtl/ram4_bank.sv
`default_nettype none
// ============================================================================
// Module   : ram4_bank
// Purpose  : Four-word register bank with address-steered load, combinational
//            4-to-1 read, per-word written flags and a one-word-per-cycle
//            clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module ram4_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [1:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             word_valid,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [4];
  logic [WIDTH-1:0] mem_d [4];
  logic [3:0]       vld_q, vld_d;

  // Read path: zero-latency select of the addressed word and its flag
  always_comb begin
    out        = mem_q[address];
    word_valid = vld_q[address];
    busy       = busy_q;
  end

  // Next-state: writes in IDLE (clear has priority), one word zeroed per SWEEP cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          // A simultaneous load is intentionally dropped
          state_d = SWEEP;
          idx_d   = 2'd0;
          busy_d  = 1'b1;
        end else if (load) begin
          mem_d[address] = in;
          vld_d[address] = 1'b1;
        end
      end
      SWEEP: begin
        // load and clear are ignored until the sweep finishes
        mem_d[idx_q] = '0;
        vld_d[idx_q] = 1'b0;
        if (idx_q == 2'd3) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any sweep and empties the bank
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      vld_q   <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram4_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram4_bank
// Purpose  : Directed scoreboard bench for ram4_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram4_bank;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [1:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        word_valid;
  logic        busy;

  typedef struct {
    string       name;
    logic [15:0] out;
    logic        wv;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  bit   chk_req;
  int   total;
  int   bad;

  ram4_bank #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .load       (load),
    .address    (address),
    .clear      (clear),
    .out        (out),
    .word_valid (word_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge; optionally queue the
  // expected read-side view for that cycle.
  task automatic cyc(input logic rst, input logic ld, input logic clr,
                     input logic [1:0] a, input logic [15:0] d,
                     input bit chk, input logic [15:0] eo,
                     input logic ewv, input logic eb, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = rst;
    load    = ld;
    clear   = clr;
    address = a;
    in      = d;
    if (chk) begin
      e.name = nm;
      e.out  = eo;
      e.wv   = ewv;
      e.busy = eb;
      exp_q.push_back(e);
    end
    chk_req = chk;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d, 1'b0, 16'h0, 1'b0, 1'b0, "");
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] eo,
                    input logic ewv, input logic eb, input string nm);
    cyc(1'b0, 1'b0, 1'b0, a, 16'h0, 1'b1, eo, ewv, eb, nm);
  endtask

  // Monitor: compare DUT outputs against the scoreboard away from the edge
  always @(negedge clk) begin
    if (chk_req) begin
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: got out=%h wv=%b busy=%b, required a queued expectation",
                 out, word_valid, busy);
      end else begin
        e = exp_q.pop_front();
        if (out !== e.out || word_valid !== e.wv || busy !== e.busy) begin
          bad++;
          $display("FAIL %s: got out=%h wv=%b busy=%b, required out=%h wv=%b busy=%b",
                   e.name, out, word_valid, busy, e.out, e.wv, e.busy);
        end
      end
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    chk_req = 1'b0;
    reset   = 1'b1;
    load    = 1'b0;
    clear   = 1'b0;
    address = 2'd0;
    in      = 16'h0;

    // Reset state of every word
    for (int i = 0; i < 4; i++) rd(2'(i), 16'h0000, 1'b0, 1'b0, "reset_word");

    // Fill and read back
    wr(2'd0, 16'h1111); wr(2'd1, 16'h2222); wr(2'd2, 16'h3333); wr(2'd3, 16'h4444);
    rd(2'd0, 16'h1111, 1'b1, 1'b0, "rb_word0");
    rd(2'd1, 16'h2222, 1'b1, 1'b0, "rb_word1");
    rd(2'd2, 16'h3333, 1'b1, 1'b0, "rb_word2");
    rd(2'd3, 16'h4444, 1'b1, 1'b0, "rb_word3");

    // Clear sweep observed on address 2 (edge T at end of this cycle)
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 16'h0, 1'b1, 16'h3333, 1'b1, 1'b0, "sweep_pre");
    rd(2'd2, 16'h3333, 1'b1, 1'b1, "sweep_T");
    rd(2'd2, 16'h3333, 1'b1, 1'b1, "sweep_T1");
    rd(2'd2, 16'h3333, 1'b1, 1'b1, "sweep_T2");
    rd(2'd2, 16'h0000, 1'b0, 1'b1, "sweep_T3_word2_zero");
    rd(2'd3, 16'h0000, 1'b0, 1'b0, "sweep_T4_idle");
    rd(2'd0, 16'h0000, 1'b0, 1'b0, "sweep_word0_zero");
    rd(2'd1, 16'h0000, 1'b0, 1'b0, "sweep_word1_zero");

    // Sweep with a load and a second clear issued mid-sweep
    wr(2'd0, 16'h1111); wr(2'd1, 16'h2222); wr(2'd2, 16'h3333); wr(2'd3, 16'h4444);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, "");
    cyc(1'b0, 1'b1, 1'b1, 2'd3, 16'hBEEF, 1'b1, 16'h4444, 1'b1, 1'b1, "mid_load_clear");
    rd(2'd3, 16'h4444, 1'b1, 1'b1, "mid_T1_dropped");
    rd(2'd3, 16'h4444, 1'b1, 1'b1, "mid_T2");
    rd(2'd3, 16'h4444, 1'b1, 1'b1, "mid_T3");
    rd(2'd3, 16'h0000, 1'b0, 1'b0, "mid_T4_word3_zero");
    rd(2'd3, 16'h0000, 1'b0, 1'b0, "mid_not_extended");

    // Zero write sets the flag; back-to-back writes, last one wins
    wr(2'd2, 16'h0000);
    rd(2'd2, 16'h0000, 1'b1, 1'b0, "zero_write_valid");
    wr(2'd2, 16'hAAAA); wr(2'd2, 16'hBBBB);
    rd(2'd2, 16'hBBBB, 1'b1, 1'b0, "last_write_wins");

    // Load+clear together in IDLE: clear wins, then reset aborts the sweep
    wr(2'd3, 16'h7777); wr(2'd1, 16'h1234);
    cyc(1'b0, 1'b1, 1'b1, 2'd1, 16'hAAAA, 1'b1, 16'h1234, 1'b1, 1'b0, "ldclr_pre");
    rd(2'd1, 16'h1234, 1'b1, 1'b1, "ldclr_write_dropped");
    cyc(1'b1, 1'b0, 1'b0, 2'd3, 16'h0, 1'b1, 16'h7777, 1'b1, 1'b1, "abort_pre");
    rd(2'd3, 16'h0000, 1'b0, 1'b0, "abort_word3");
    rd(2'd1, 16'h0000, 1'b0, 1'b0, "abort_word1");
    rd(2'd2, 16'h0000, 1'b0, 1'b0, "abort_word2");
    wr(2'd0, 16'h5555);
    rd(2'd0, 16'h5555, 1'b1, 1'b0, "post_reset_write");

    @(posedge clk);
    #1;
    chk_req = 1'b0;
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
